// File: rtl/pong_text_pkg.sv
// Shared constants for the text tile buffer: screen geometry, blank glyph,
// control codes and the writer FSM state type.
package pong_text_pkg;

    // Tile grid shared with the character generation circuit.
    localparam int COLS = 80;
    localparam int ROWS = 30;

    // Code written by clear and backspace (blank glyph).
    localparam logic [6:0] CLEAR_CHAR = 7'h00;

    // Control codes interpreted by the writer.
    localparam logic [6:0] CC_BS = 7'h08;
    localparam logic [6:0] CC_LF = 7'h0A;
    localparam logic [6:0] CC_FF = 7'h0C;
    localparam logic [6:0] CC_CR = 7'h0D;

    // Last valid column / row, sized to the cursor counters.
    localparam logic [6:0] LAST_X = 7'(COLS - 1);
    localparam logic [4:0] LAST_Y = 5'(ROWS - 1);

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    // Tile RAM address is {row, col}; cols >= COLS are never written.
    function automatic logic [11:0] tile_addr(
        input logic [4:0] row,
        input logic [6:0] col
    );
        return {row, col};
    endfunction

endpackage

// File: rtl/tile_cursor.sv
// Text cursor position register.
// Ports: clk, reset (sync, active-low); advance/newline/cr/retreat/home
// single-cycle move requests (mutually exclusive); x, y position; at_origin.
import pong_text_pkg::*;

module tile_cursor (
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    input  logic       newline,
    input  logic       cr,
    input  logic       retreat,
    input  logic       home,
    output logic [6:0] x,
    output logic [4:0] y,
    output logic       at_origin
);

    logic [4:0] y_next_row;
    logic [4:0] y_prev_row;

    // Row moves wrap by compare, not by counter overflow.
    always_comb begin
        y_next_row = (y == LAST_Y) ? 5'd0 : y + 5'd1;
        y_prev_row = (y == 5'd0) ? LAST_Y : y - 5'd1;
    end

    assign at_origin = (x == 7'd0) && (y == 5'd0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            x <= 7'd0;
            y <= 5'd0;
        end else begin
            unique case (1'b1)
                home: begin
                    x <= 7'd0;
                    y <= 5'd0;
                end
                advance: begin
                    if (x == LAST_X) begin
                        x <= 7'd0;
                        y <= y_next_row;
                    end else begin
                        x <= x + 7'd1;
                    end
                end
                newline: begin
                    x <= 7'd0;
                    y <= y_next_row;
                end
                cr: begin
                    x <= 7'd0;
                end
                retreat: begin
                    // Caller never retreats from the origin.
                    if (x != 7'd0) begin
                        x <= x - 7'd1;
                    end else begin
                        x <= LAST_X;
                        y <= y_prev_row;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/text_tile_writer.sv
// Write side of the text tile buffer: turns a character stream into tile RAM
// writes, tracks the cursor, interprets control codes and runs a clear sweep.
// Ports: clk, reset (sync, active-low); char_valid/char_data/char_ready input
// stream; clear_req; wr_en/wr_addr/wr_data tile RAM write port;
// cursor_x/cursor_y cursor position; busy during the clear sweep.
import pong_text_pkg::*;

module text_tile_writer (
    input  logic        clk,
    input  logic        reset,
    input  logic        char_valid,
    input  logic [6:0]  char_data,
    output logic        char_ready,
    input  logic        clear_req,
    output logic        wr_en,
    output logic [11:0] wr_addr,
    output logic [6:0]  wr_data,
    output logic [6:0]  cursor_x,
    output logic [4:0]  cursor_y,
    output logic        busy
);

    state_t     state;
    logic [6:0] sweep_col;
    logic [4:0] sweep_row;
    logic [6:0] sweep_col_nx;
    logic [4:0] sweep_row_nx;
    logic       sweep_last;

    logic       xfer;
    logic       is_lf;
    logic       is_cr;
    logic       is_bs;
    logic       is_ff;
    logic       is_print;
    logic       start_clear;

    logic       cur_advance;
    logic       cur_newline;
    logic       cur_cr;
    logic       cur_retreat;
    logic       cur_home;
    logic       at_origin;

    logic [6:0] bs_x;
    logic [4:0] bs_y;

    // Gated by reset so nothing is accepted while reset is held.
    assign char_ready = reset && (state == ST_IDLE) && !clear_req;
    assign xfer       = char_valid && char_ready;

    always_comb begin
        is_lf    = (char_data == CC_LF);
        is_cr    = (char_data == CC_CR);
        is_bs    = (char_data == CC_BS);
        is_ff    = (char_data == CC_FF);
        is_print = !(is_lf || is_cr || is_bs || is_ff);
    end

    assign start_clear = (state == ST_IDLE)
                      && (clear_req || (xfer && is_ff));

    // Backspace target: the cell the cursor retreats onto.
    always_comb begin
        if (cursor_x != 7'd0) begin
            bs_x = cursor_x - 7'd1;
            bs_y = cursor_y;
        end else begin
            bs_x = LAST_X;
            bs_y = cursor_y - 5'd1;
        end
    end

    always_comb begin
        sweep_last = (sweep_col == LAST_X) && (sweep_row == LAST_Y);
        if (sweep_col == LAST_X) begin
            sweep_col_nx = 7'd0;
            sweep_row_nx = sweep_row + 5'd1;
        end else begin
            sweep_col_nx = sweep_col + 7'd1;
            sweep_row_nx = sweep_row;
        end
    end

    always_comb begin
        cur_advance = xfer && is_print;
        cur_newline = xfer && is_lf;
        cur_cr      = xfer && is_cr;
        cur_retreat = xfer && is_bs && !at_origin;
        cur_home    = (state == ST_CLEAR) && sweep_last;
    end

    tile_cursor u_cursor (
        .clk       (clk),
        .reset     (reset),
        .advance   (cur_advance),
        .newline   (cur_newline),
        .cr        (cur_cr),
        .retreat   (cur_retreat),
        .home      (cur_home),
        .x         (cursor_x),
        .y         (cursor_y),
        .at_origin (at_origin)
    );

    // The write for a transfer, and every sweep write, is registered here so
    // it lands on the port one cycle later, aligned with the cursor update.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            wr_en     <= 1'b0;
            wr_addr   <= 12'd0;
            wr_data   <= 7'd0;
            busy      <= 1'b0;
            sweep_col <= 7'd0;
            sweep_row <= 5'd0;
        end else begin
            wr_en <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start_clear) begin
                        // First sweep write goes out with the state change.
                        state     <= ST_CLEAR;
                        busy      <= 1'b1;
                        wr_en     <= 1'b1;
                        wr_addr   <= tile_addr(5'd0, 7'd0);
                        wr_data   <= CLEAR_CHAR;
                        sweep_col <= 7'd0;
                        sweep_row <= 5'd0;
                    end else if (cur_advance) begin
                        wr_en   <= 1'b1;
                        wr_addr <= tile_addr(cursor_y, cursor_x);
                        wr_data <= char_data;
                    end else if (cur_retreat) begin
                        wr_en   <= 1'b1;
                        wr_addr <= tile_addr(bs_y, bs_x);
                        wr_data <= CLEAR_CHAR;
                    end
                end
                ST_CLEAR: begin
                    if (sweep_last) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        wr_en     <= 1'b1;
                        wr_addr   <= tile_addr(sweep_row_nx, sweep_col_nx);
                        wr_data   <= CLEAR_CHAR;
                        sweep_col <= sweep_col_nx;
                        sweep_row <= sweep_row_nx;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_text_tile_writer.sv
// Randomised and directed bench for text_tile_writer against a linear-position
// reference model of the screen cursor and clear sweep.
module tb_text_tile_writer;

    localparam int NCOLS  = 80;
    localparam int NROWS  = 30;
    localparam int NTILES = NCOLS * NROWS;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        char_valid = 1'b0;
    logic [6:0]  char_data = 7'd0;
    logic        char_ready;
    logic        clear_req = 1'b0;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [6:0]  wr_data;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int  pos = 0;
    int  idx = 0;
    bit  m_clear = 0;
    bit  primed = 0;
    bit  e_wen = 0;
    int  e_addr = 0;
    int  e_data = 0;
    bit  e_busy = 0;

    always #5 clk = ~clk;

    text_tile_writer dut (
        .clk        (clk),
        .reset      (reset),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .clear_req  (clear_req),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int addr_of(input int p);
        return (p / NCOLS) * 128 + (p % NCOLS);
    endfunction

    function automatic logic [6:0] printable();
        logic [6:0] d;
        do begin
            d = 7'($urandom_range(0, 127));
        end while (d == 7'h08 || d == 7'h0A || d == 7'h0C || d == 7'h0D);
        return d;
    endfunction

    task automatic check_outputs();
        chk("wr_en", 32'(wr_en), 32'(e_wen));
        chk("wr_addr", 32'(wr_addr), e_addr);
        chk("wr_data", 32'(wr_data), e_data);
        chk("cursor_x", 32'(cursor_x), pos % NCOLS);
        chk("cursor_y", 32'(cursor_y), pos / NCOLS);
        chk("busy", 32'(busy), 32'(e_busy));
    endtask

    task automatic model(input bit rst, input bit v, input logic [6:0] d,
                         input bit clr, input bit rdy);
        bit x;
        x = v && rdy;
        if (!rst) begin
            m_clear = 0; pos = 0; e_wen = 0;
            e_addr = 0; e_data = 0; e_busy = 0;
        end else if (m_clear) begin
            if (idx == NTILES - 1) begin
                m_clear = 0; pos = 0; e_wen = 0; e_busy = 0;
            end else begin
                idx++;
                e_wen = 1; e_addr = addr_of(idx); e_data = 0;
            end
        end else if (clr || (x && d == 7'h0C)) begin
            m_clear = 1; idx = 0;
            e_wen = 1; e_addr = 0; e_data = 0; e_busy = 1;
        end else if (x) begin
            e_wen = 0;
            case (d)
                7'h0A: pos = (((pos / NCOLS) + 1) % NROWS) * NCOLS;
                7'h0D: pos = pos - (pos % NCOLS);
                7'h08: begin
                    if (pos > 0) begin
                        pos--;
                        e_wen = 1; e_addr = addr_of(pos); e_data = 0;
                    end
                end
                default: begin
                    e_wen = 1; e_addr = addr_of(pos); e_data = d;
                    pos = (pos + 1) % NTILES;
                end
            endcase
        end else begin
            e_wen = 0;
        end
    endtask

    task automatic step(input bit rst, input bit v, input logic [6:0] d,
                        input bit clr);
        bit rdy;
        @(negedge clk);
        if (primed) check_outputs();
        reset = rst; char_valid = v; char_data = d; clear_req = clr;
        #1;
        rdy = rst && !m_clear && !clr;
        chk("char_ready", 32'(char_ready), 32'(rdy));
        model(rst, v, d, clr, rdy);
        primed = 1;
    endtask

    task automatic send(input logic [6:0] d);
        step(1, 1, d, 0);
    endtask

    task automatic idle();
        step(1, 0, 7'd0, 0);
    endtask

    initial begin
        // Reset held with a character offered
        repeat (3) step(0, 1, 7'h41, 0);
        // 'A','B' back to back
        send(7'h41);
        send(7'h42);
        idle();
        // Fill row 0 exactly
        send(7'h0D);
        repeat (80) send(printable());
        idle();
        // Newline down to row 29, then wrap to row 0
        repeat (28) send(7'h0A);
        send(7'h0A);
        idle();
        // Backspace across a row boundary, then at origin
        send(7'h0A);
        send(7'h08);
        send(7'h0D);
        send(7'h08);
        idle();
        // Clear request competing with a character
        step(1, 1, 7'h41, 1);
        repeat (NTILES + 1) step(1, 1, printable(), 1);
        idle();
        // Form feed sweep aborted by reset
        send(printable());
        send(7'h0C);
        repeat (999) idle();
        step(0, 0, 7'd0, 0);
        send(7'h41);
        idle();
        // Random traffic
        for (int i = 0; i < 9000; i++) begin
            bit v;
            bit clr;
            bit rst;
            logic [6:0] d;
            int k;
            v = ($urandom_range(0, 99) < 75);
            clr = ($urandom_range(0, 2999) == 0);
            rst = ($urandom_range(0, 1499) != 0);
            k = $urandom_range(0, 19);
            if (k == 0) d = 7'h0A;
            else if (k == 1) d = 7'h0D;
            else if (k <= 5) d = 7'h08;
            else if (k == 6 && $urandom_range(0, 199) == 0) d = 7'h0C;
            else d = printable();
            step(rst, v, d, clr);
        end
        @(negedge clk);
        check_outputs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
